// File: rtl/tilelink_mto1_rr_pkg.sv
// tl_mto1_pkg: TileLink opcodes, arbiter state type and burst-length helpers for tilelink_mto1_rr
package tl_mto1_pkg;
  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] ArithmeticData = 3'd2;
  localparam logic [2:0] LogicalData    = 3'd3;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] Intent         = 3'd5;
  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;

  typedef enum logic {IDLE, BURST} arb_state_t;

  function automatic logic has_data_a(input logic [2:0] opcode);
    return opcode <= LogicalData;
  endfunction

  // Beats minus one for a message of 2^size bytes; sizes beyond 4 KiB count as one beat.
  function automatic logic [11:0] beats_m1(input int size, input int beat_lg);
    return (size <= beat_lg || size > 12) ? 12'd0 : 12'((1 << (size - beat_lg)) - 1);
  endfunction
endpackage

// File: rtl/tilelink_mto1_rr_if.sv
// tilelink_mto1_rr_if: N-lane packed TileLink-UL/UH A/D bus (lane i at slice i)
// master modport drives A and consumes D; slave modport consumes A and drives D.
interface tilelink_mto1_rr_if #(
  parameter int N  = 1,
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int SW = 4,
  parameter int SZ = 4
);
  logic [3*N-1:0]      a_opcode, a_param;
  logic [SZ*N-1:0]     a_size;
  logic [SW*N-1:0]     a_source;
  logic [AW*N-1:0]     a_address;
  logic [DW/8*N-1:0]   a_mask;
  logic [DW*N-1:0]     a_data;
  logic [N-1:0]        a_corrupt, a_valid, a_ready;
  logic [3*N-1:0]      d_opcode;
  logic [2*N-1:0]      d_param;
  logic [SZ*N-1:0]     d_size;
  logic [SW*N-1:0]     d_source;
  logic [DW*N-1:0]     d_data;
  logic [N-1:0]        d_denied, d_corrupt, d_valid, d_ready;

  modport master (
    output a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid, d_ready,
    input  a_ready, d_opcode, d_param, d_size, d_source, d_data, d_denied, d_corrupt, d_valid
  );
  modport slave (
    input  a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt, a_valid, d_ready,
    output a_ready, d_opcode, d_param, d_size, d_source, d_data, d_denied, d_corrupt, d_valid
  );
endinterface

// File: rtl/tilelink_mto1_rr_arbiter.sv
// tl_rr_arbiter: round-robin grant over req with an optional lock onto one index
// Ports: req, advance (grant accepted), lock_en/lock_idx in; one-hot grant and grant_idx out.
module tl_rr_arbiter #(
  parameter int M = 4
) (
  input  logic                 tilelink_clock_i,
  input  logic                 tilelink_reset_i,
  input  logic [M-1:0]         req,
  input  logic                 advance,
  input  logic                 lock_en,
  input  logic [$clog2(M)-1:0] lock_idx,
  output logic [M-1:0]         grant,
  output logic [$clog2(M)-1:0] grant_idx
);
  localparam int MW = $clog2(M);
  logic [MW-1:0] rr_ptr, rr_idx;
  // Scan downward so the last hit is the first requester at or after rr_ptr.
  always_comb begin
    rr_idx = '0;
    for (int k = M - 1; k >= 0; k--)
      if (req[(int'(rr_ptr) + k) % M]) rr_idx = MW'((int'(rr_ptr) + k) % M);
    grant_idx = lock_en ? lock_idx : rr_idx;
    grant = req & (M'(1) << grant_idx);
  end
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i)
    if (!tilelink_reset_i) rr_ptr <= '0;
    else if (advance) rr_ptr <= (int'(grant_idx) == M - 1) ? '0 : grant_idx + 1'b1;
endmodule

// File: rtl/tilelink_mto1_rr.sv
// tilelink_mto1_rr: M-to-1 TileLink-UL/UH merger, round-robin A arbitration with burst lock, source-routed D
// Ports: tilelink_clock_i, tilelink_reset_i (async, active-low); m = M master lanes; s = single slave lane
// whose source is {master index, master source}. Define TL_MTO1_OUTSTANDING_LIMIT_EN to cap in-flight
// requests per master at MAX_OUTSTANDING.
module tilelink_mto1_rr
  import tl_mto1_pkg::*;
#(
  parameter int M               = 4,
  parameter int TL_DW           = 32,
  parameter int TL_AW           = 32,
  parameter int TL_RS           = 4,
  parameter int TL_SZ           = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input logic tilelink_clock_i,
  input logic tilelink_reset_i,
  tilelink_mto1_rr_if.slave  m,
  tilelink_mto1_rr_if.master s
);
  localparam int MW      = $clog2(M);
  localparam int MB      = TL_DW / 8;
  localparam int BEAT_LG = $clog2(MB);
  logic [M-1:0] full, req, grant;
  logic [MW-1:0] gi, lock_q, lock_d;
  logic [11:0] a_cnt_q, a_cnt_d, a_bm1;
  arb_state_t state_q, state_d;
  logic can_load, acc;
  logic [2:0] a_op;
  logic [TL_SZ-1:0] a_sz;
  // Outstanding limits gate only fresh arbitration; a locked burst always continues.
  assign req = m.a_valid & ~(full & {M{state_q == IDLE}});
  tl_rr_arbiter #(.M(M)) u_arb (
    .tilelink_clock_i, .tilelink_reset_i, .req, .advance(acc),
    .lock_en(state_q == BURST), .lock_idx(lock_q), .grant, .grant_idx(gi)
  );
  assign can_load  = !s.a_valid || s.a_ready;
  assign acc       = |grant && can_load;
  assign m.a_ready = grant & {M{can_load}};
  assign a_op      = m.a_opcode[gi*3 +: 3];
  assign a_sz      = m.a_size[gi*TL_SZ +: TL_SZ];
  assign a_bm1     = beats_m1(int'(a_sz), BEAT_LG);
  always_comb begin
    state_d = state_q;
    a_cnt_d = a_cnt_q;
    lock_d  = lock_q;
    if (acc && state_q == IDLE && has_data_a(a_op) && a_bm1 != '0) begin
      state_d = BURST;
      a_cnt_d = a_bm1;
      lock_d  = gi;
    end else if (acc && state_q == BURST) begin
      a_cnt_d = a_cnt_q - 1'b1;
      state_d = a_cnt_q == 12'd1 ? IDLE : BURST;
    end
  end
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i)
    if (!tilelink_reset_i) begin
      state_q   <= IDLE;
      a_cnt_q   <= '0;
      lock_q    <= '0;
      s.a_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      lock_q  <= lock_d;
      if (can_load) s.a_valid <= acc;
    end
  always_ff @(posedge tilelink_clock_i)
    if (acc) begin
      s.a_opcode  <= a_op;
      s.a_param   <= m.a_param[gi*3 +: 3];
      s.a_size    <= a_sz;
      s.a_source  <= {gi, m.a_source[gi*TL_RS +: TL_RS]};
      s.a_address <= m.a_address[gi*TL_AW +: TL_AW];
      s.a_mask    <= m.a_mask[gi*MB +: MB];
      s.a_data    <= m.a_data[gi*TL_DW +: TL_DW];
      s.a_corrupt <= m.a_corrupt[gi];
    end
  logic d_valid_q, d_den_q, d_cor_q, sel_ok, d_take;
  logic [2:0] d_op_q;
  logic [1:0] d_par_q;
  logic [TL_SZ-1:0] d_size_q;
  logic [TL_RS-1:0] d_src_q;
  logic [TL_DW-1:0] d_data_q;
  logic [MW-1:0] d_sel_q;
  // Beats routed to a nonexistent master are consumed silently so the slave never stalls.
  assign sel_ok    = int'(d_sel_q) < M;
  assign d_take    = d_valid_q && (!sel_ok || m.d_ready[d_sel_q]);
  assign s.d_ready = !d_valid_q || d_take;
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i)
    if (!tilelink_reset_i) d_valid_q <= 1'b0;
    else if (s.d_ready) d_valid_q <= s.d_valid;
  always_ff @(posedge tilelink_clock_i)
    if (s.d_ready && s.d_valid) begin
      d_op_q   <= s.d_opcode;
      d_par_q  <= s.d_param;
      d_size_q <= s.d_size;
      d_src_q  <= s.d_source[TL_RS-1:0];
      d_sel_q  <= s.d_source[TL_RS +: MW];
      d_data_q <= s.d_data;
      d_den_q  <= s.d_denied;
      d_cor_q  <= s.d_corrupt;
    end
  assign m.d_opcode  = {M{d_op_q}};
  assign m.d_param   = {M{d_par_q}};
  assign m.d_size    = {M{d_size_q}};
  assign m.d_source  = {M{d_src_q}};
  assign m.d_data    = {M{d_data_q}};
  assign m.d_denied  = {M{d_den_q}};
  assign m.d_corrupt = {M{d_cor_q}};
  always_comb
    for (int i = 0; i < M; i++) m.d_valid[i] = d_valid_q && int'(d_sel_q) == i;
`ifdef TL_MTO1_OUTSTANDING_LIMIT_EN
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  logic [OW-1:0] out_cnt [M];
  logic [11:0] d_cnt_q, d_bm1;
  logic d_last;
  assign d_bm1  = d_op_q == AccessAckData ? beats_m1(int'(d_size_q), BEAT_LG) : 12'd0;
  // d_cnt_q==0 marks the first beat of a D message; otherwise it counts remaining beats.
  assign d_last = d_take && (d_cnt_q == '0 ? d_bm1 == '0 : d_cnt_q == 12'd1);
  always_ff @(posedge tilelink_clock_i or negedge tilelink_reset_i)
    if (!tilelink_reset_i) begin
      d_cnt_q <= '0;
      for (int i = 0; i < M; i++) out_cnt[i] <= '0;
    end else begin
      if (d_take) d_cnt_q <= d_cnt_q == '0 ? d_bm1 : d_cnt_q - 1'b1;
      for (int i = 0; i < M; i++)
        out_cnt[i] <= out_cnt[i] + OW'(acc && grant[i] && state_q == IDLE)
                                 - OW'(d_last && sel_ok && int'(d_sel_q) == i);
    end
  always_comb
    for (int i = 0; i < M; i++) full[i] = out_cnt[i] == OW'(MAX_OUTSTANDING);
`else
  assign full = '0;
`endif
endmodule

// File: tb/tb_tilelink_mto1_rr.sv
// tb_tilelink_mto1_rr: directed self-checking bench for tilelink_mto1_rr (M=4, TL_DW=32)
module tb_tilelink_mto1_rr;
  import tl_mto1_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;

  tilelink_mto1_rr_if #(.N(4), .DW(32), .AW(32), .SW(4), .SZ(4)) mif ();
  tilelink_mto1_rr_if #(.N(1), .DW(32), .AW(32), .SW(6), .SZ(4)) sif ();

  tilelink_mto1_rr #(
    .M(4), .TL_DW(32), .TL_AW(32), .TL_RS(4), .TL_SZ(4), .MAX_OUTSTANDING(2)
  ) dut (
    .tilelink_clock_i(clk),
    .tilelink_reset_i(rst_n),
    .m(mif),
    .s(sif)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_a(input int i, input logic [2:0] op, input logic [3:0] sz,
                         input logic [3:0] src, input logic [31:0] dat);
    mif.a_opcode[i*3 +: 3]    = op;
    mif.a_param[i*3 +: 3]     = 3'd0;
    mif.a_size[i*4 +: 4]      = sz;
    mif.a_source[i*4 +: 4]    = src;
    mif.a_address[i*32 +: 32] = dat;
    mif.a_mask[i*4 +: 4]      = 4'hF;
    mif.a_data[i*32 +: 32]    = dat;
    mif.a_corrupt[i]          = 1'b0;
    mif.a_valid[i]            = 1'b1;
  endtask

  task automatic drive_d(input logic [2:0] op, input logic [3:0] sz,
                         input logic [5:0] src, input logic [31:0] dat);
    sif.d_opcode  = op;
    sif.d_param   = 2'd0;
    sif.d_size    = sz;
    sif.d_source  = src;
    sif.d_data    = dat;
    sif.d_denied  = 1'b0;
    sif.d_corrupt = 1'b0;
    sif.d_valid   = 1'b1;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc();
  endtask

  initial begin
    mif.a_opcode = '0; mif.a_param = '0; mif.a_size = '0; mif.a_source = '0;
    mif.a_address = '0; mif.a_mask = '0; mif.a_data = '0; mif.a_corrupt = '0;
    mif.a_valid = '0; mif.d_ready = '1;
    sif.a_ready = 1'b1;
    sif.d_opcode = '0; sif.d_param = '0; sif.d_size = '0; sif.d_source = '0;
    sif.d_data = '0; sif.d_denied = '0; sif.d_corrupt = '0; sif.d_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a_valid", sif.a_valid, 1'b0);
    chk("reset_d_valid", mif.d_valid, 4'b0000);
    chk("reset_state", dut.state_q, IDLE);
    rst_n = 1'b1;
    cyc();

`ifdef TL_MTO1_OUTSTANDING_LIMIT_EN
    drive_a(0, Get, 4'd2, 4'h1, 32'h0);
    #1 chk("lim_rdy1", mif.a_ready[0], 1'b1);
    cyc();
    chk("lim_src1", sif.a_source, 6'h01);
    mif.a_source[3:0] = 4'h2;
    #1 chk("lim_rdy2", mif.a_ready[0], 1'b1);
    cyc();
    chk("lim_src2", sif.a_source, 6'h02);
    mif.a_source[3:0] = 4'h3;
    #1 chk("lim_stall", mif.a_ready[0], 1'b0);
    cyc();
    chk("lim_no_a", sif.a_valid, 1'b0);
    drive_d(AccessAckData, 4'd2, 6'h01, 32'h5);
    cyc();
    sif.d_valid = 1'b0;
    chk("lim_d_valid", mif.d_valid, 4'b0001);
    chk("lim_still", mif.a_ready[0], 1'b0);
    cyc();
    chk("lim_release", mif.a_ready[0], 1'b1);
    cyc();
    chk("lim_src3", sif.a_source, 6'h03);
    mif.a_valid[0] = 1'b0;
    do_reset();
`endif

    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 4; i++) drive_a(i, Get, 4'd2, 4'(i + 5), 32'(i));
      for (int k = 0; k < 4; k++) begin
        #1 chk($sformatf("rr_ready_r%0d_k%0d", r, k), mif.a_ready, 4'b0001 << k);
        cyc();
        chk($sformatf("rr_src_r%0d_k%0d", r, k), sif.a_source, {2'(k), 4'(k + 5)});
        mif.a_valid[k] = 1'b0;
      end
      cyc();
      chk("rr_idle", sif.a_valid, 1'b0);
    end
    do_reset();

    drive_a(1, PutFullData, 4'd4, 4'h7, 32'hA0);
    drive_a(2, Get, 4'd2, 4'h2, 32'h0);
    for (int b = 0; b < 4; b++) begin
      #1 chk($sformatf("burst_ready_b%0d", b), mif.a_ready, 4'b0010);
      cyc();
      chk($sformatf("burst_src_b%0d", b), sif.a_source, {2'd1, 4'h7});
      chk($sformatf("burst_data_b%0d", b), sif.a_data, 32'hA0 + b);
      mif.a_data[63:32] = 32'hA0 + b + 1;
    end
    mif.a_valid[1] = 1'b0;
    #1 chk("after_burst_ready", mif.a_ready, 4'b0100);
    cyc();
    chk("after_burst_src", sif.a_source, {2'd2, 4'h2});
    mif.a_valid[2] = 1'b0;

    drive_a(0, PutFullData, 4'd4, 4'h3, 32'h100);
    for (int b = 0; b < 2; b++) begin
      cyc();
      chk($sformatf("bp_data_b%0d", b), sif.a_data, 32'h100 + b);
      mif.a_data[31:0] = 32'h100 + b + 1;
    end
    sif.a_ready = 1'b0;
    #1 chk("bp_ready_low", mif.a_ready, 4'b0000);
    for (int c = 0; c < 3; c++) begin
      cyc();
      chk($sformatf("bp_hold_%0d", c), sif.a_data, 32'h101);
      chk($sformatf("bp_valid_%0d", c), sif.a_valid, 1'b1);
    end
    chk("bp_cnt", dut.a_cnt_q, 12'd2);
    sif.a_ready = 1'b1;
    for (int b = 2; b < 4; b++) begin
      #1 chk($sformatf("bp_ready_b%0d", b), mif.a_ready, 4'b0001);
      cyc();
      chk($sformatf("bp_data_b%0d", b), sif.a_data, 32'h100 + b);
      mif.a_data[31:0] = 32'h100 + b + 1;
    end
    mif.a_valid[0] = 1'b0;
    cyc();
    chk("bp_done_valid", sif.a_valid, 1'b0);
    chk("bp_done_state", dut.state_q, IDLE);

    drive_d(AccessAckData, 4'd4, {2'd3, 4'hA}, 32'hD0);
    #1 chk("d_ready_init", sif.d_ready, 1'b1);
    cyc();
    chk("d_valid_b0", mif.d_valid, 4'b1000);
    chk("d_src_b0", mif.d_source[15:12], 4'hA);
    chk("d_data_b0", mif.d_data[127:96], 32'hD0);
    sif.d_data = 32'hD1;
    mif.d_ready[3] = 1'b0;
    #1 chk("d_bp_ready", sif.d_ready, 1'b0);
    cyc();
    chk("d_bp_hold", mif.d_data[127:96], 32'hD0);
    mif.d_ready[3] = 1'b1;
    #1 chk("d_bp_release", sif.d_ready, 1'b1);
    for (int b = 1; b < 4; b++) begin
      cyc();
      chk($sformatf("d_valid_b%0d", b), mif.d_valid, 4'b1000);
      chk($sformatf("d_data_b%0d", b), mif.d_data[127:96], 32'hD0 + b);
      if (b < 3) sif.d_data = 32'hD0 + b + 1;
      else sif.d_valid = 1'b0;
    end
    cyc();
    chk("d_done", mif.d_valid, 4'b0000);

    drive_a(1, PutFullData, 4'd4, 4'h1, 32'h200);
    drive_d(AccessAck, 4'd2, {2'd2, 4'h1}, 32'h0);
    cyc();
    chk("rst_pre_a", sif.a_valid, 1'b1);
    chk("rst_pre_d", mif.d_valid, 4'b0100);
    drive_a(0, Get, 4'd2, 4'h0, 32'h0);
    drive_a(3, Get, 4'd2, 4'h0, 32'h0);
    sif.d_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_a", sif.a_valid, 1'b0);
    chk("rst_async_d", mif.d_valid, 4'b0000);
    chk("rst_async_state", dut.state_q, IDLE);
    #4 rst_n = 1'b1;
    #1 chk("rst_grant_ready", mif.a_ready, 4'b0001);
    cyc();
    chk("rst_grant_src", sif.a_source[5:4], 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
